// File: rtl/ad_pkg.sv
// Shared types and constants for the dual-ADC serial command/readback link.
// Optional strobe timeout is enabled with the AD_STRB_TIMEOUT_EN macro.
package ad_pkg;

   localparam int AD_CMD_W  = 8;
   localparam int AD_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WAIT_STRB,
      READ,
      DONE
   } ad_state_t;

   function automatic int bit_cnt_w(input int bits);
      return $clog2(bits + 1);
   endfunction

   localparam int AD_BIT_W = bit_cnt_w(AD_DATA_W);

endpackage

// File: rtl/ad_sclk_gen.sv
// SCLK phase divider: each bit is CLK_DIV cycles low then CLK_DIV cycles high.
// Held in phase 0 with SCLK low whenever run is deasserted.
module ad_sclk_gen
   import ad_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic sclk,
   output logic fall_tick,
   output logic rise_end_tick
);

   localparam int PW = $clog2(2 * CLK_DIV);
   localparam logic [PW-1:0] LOW_END  = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] HIGH_END = PW'(2 * CLK_DIV - 1);

   logic [PW-1:0] cnt;

   // sclk is registered so it changes on the same edge the phase counter does
   always_ff @(posedge clk) begin
      if (reset || !run) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else begin
         cnt <= (cnt == HIGH_END) ? '0 : cnt + 1'b1;
         if (cnt == LOW_END) begin
            sclk <= 1'b1;
         end else if (cnt == HIGH_END) begin
            sclk <= 1'b0;
         end
      end
   end

   assign fall_tick     = run && (cnt == '0);
   assign rise_end_tick = run && (cnt == HIGH_END);

endmodule

// File: rtl/ad_serial_ctrl.sv
// Dual-ADC serial controller: shifts a command byte out, waits for both SSTRBs,
// reads DATA_W bits from each chip in parallel. Macro AD_STRB_TIMEOUT_EN adds a strobe timeout.
module ad_serial_ctrl
   import ad_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = AD_DATA_W,
   parameter int TIMEOUT = 1023
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [AD_CMD_W-1:0] cmd_data,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   output logic                busy,
   output logic [DATA_W-1:0]   smp_data0,
   output logic [DATA_W-1:0]   smp_data1,
   output logic                smp_valid,
   output logic                smp_err,
   output logic                ad_sclk,
   output logic                ad_din,
   input  logic                ad_dout0,
   input  logic                ad_sstrb0,
   input  logic                ad_dout1,
   input  logic                ad_sstrb1
);

   localparam int BW = bit_cnt_w((DATA_W > AD_CMD_W) ? DATA_W : AD_CMD_W);

   ad_state_t           state, state_next;
   logic [3:0]          sync_meta, sync_q;
   logic                dout0_s, strb0_s, dout1_s, strb1_s;
   logic                run, fall_tick, rise_end_tick;
   logic [BW-1:0]       bit_cnt;
   logic [AD_CMD_W-1:0] cmd_sr;
   logic [DATA_W-1:0]   sr0, sr1, sr0_shift, sr1_shift;
   logic                stk0, stk1, both_seen, timeout_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= '0;
         sync_q    <= '0;
      end else begin
         sync_meta <= {ad_sstrb1, ad_dout1, ad_sstrb0, ad_dout0};
         sync_q    <= sync_meta;
      end
   end

   assign dout0_s = sync_q[0];
   assign strb0_s = sync_q[1];
   assign dout1_s = sync_q[2];
   assign strb1_s = sync_q[3];

   ad_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .sclk          (ad_sclk),
      .fall_tick     (fall_tick),
      .rise_end_tick (rise_end_tick)
   );

   // Strobes may arrive in either order; a live strobe counts as already latched
   assign both_seen = (stk0 | strb0_s) & (stk1 | strb1_s);
   assign sr0_shift = {sr0[DATA_W-2:0], dout0_s};
   assign sr1_shift = {sr1[DATA_W-2:0], dout1_s};

`ifdef AD_STRB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt;

   always_ff @(posedge clk) begin
      if (reset || state != WAIT_STRB) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timeout_hit = (to_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         smp_err <= 1'b0;
      end else if (state == IDLE && cmd_valid) begin
         smp_err <= 1'b0;
      end else if (state == WAIT_STRB && state_next == DONE) begin
         smp_err <= 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign timeout_hit    = 1'b0;
   assign smp_err        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (cmd_valid) state_next = CMD;
         CMD:       if (rise_end_tick && bit_cnt == BW'(AD_CMD_W)) state_next = WAIT_STRB;
         WAIT_STRB: begin
            if (both_seen) begin
               state_next = READ;
            end else if (timeout_hit) begin
               state_next = DONE;
            end
         end
         READ:      if (rise_end_tick && bit_cnt == BW'(DATA_W)) state_next = DONE;
         DONE:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b1;
      run       = 1'b0;
      smp_valid = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         CMD, READ: run       = 1'b1;
         DONE:      smp_valid = 1'b1;
         default: ;
      endcase
   end

   // Counts bits started, so at the last rise_end the count equals the bit total
   always_ff @(posedge clk) begin
      if (reset || state != state_next) begin
         bit_cnt <= '0;
      end else if (fall_tick) begin
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_sr    <= '0;
         ad_din    <= 1'b0;
         stk0      <= 1'b0;
         stk1      <= 1'b0;
         sr0       <= '0;
         sr1       <= '0;
         smp_data0 <= '0;
         smp_data1 <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_sr <= cmd_data;
                  ad_din <= cmd_data[AD_CMD_W-1];
                  stk0   <= 1'b0;
                  stk1   <= 1'b0;
               end
            end
            CMD: begin
               // Zeros shift in behind the byte, so DIN drops to 0 after the 8th bit
               if (rise_end_tick) begin
                  cmd_sr <= {cmd_sr[AD_CMD_W-2:0], 1'b0};
                  ad_din <= cmd_sr[AD_CMD_W-2];
               end
            end
            WAIT_STRB: begin
               stk0 <= stk0 | strb0_s;
               stk1 <= stk1 | strb1_s;
               if (state_next == DONE) begin
                  smp_data0 <= '0;
                  smp_data1 <= '0;
               end
            end
            READ: begin
               if (rise_end_tick) begin
                  sr0 <= sr0_shift;
                  sr1 <= sr1_shift;
                  if (state_next == DONE) begin
                     smp_data0 <= sr0_shift;
                     smp_data1 <= sr1_shift;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
